// File: rtl/bp_be_mem_issue_buffer.sv
// In-order memory-op issue buffer: ops stay resident from dispatch until retire so a miss can
// re-issue from the oldest unretired entry.
module bp_be_mem_issue_buffer #(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         pkt_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         pkt_o,
  input  logic                       yumi_i,
  input  logic                       retire_i,
  input  logic                       replay_i,
  output logic [$clog2(els_p):0]     count_o,
  output logic [$clog2(els_p):0]     inflight_o
);

  localparam int unsigned AddrW = $clog2(els_p);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [width_p-1:0] r_mem [els_p];
  logic [PtrW-1:0]    r_wptr, r_iptr, r_rptr;
  logic [PtrW-1:0]    w_wptr_d, w_iptr_d, w_rptr_d;
  logic [PtrW-1:0]    w_count, w_inflight;
  logic               w_enq, w_issue, w_retire;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign w_count    = r_wptr - r_rptr;
  assign w_inflight = r_iptr - r_rptr;
  assign count_o    = w_count;
  assign inflight_o = w_inflight;

  assign ready_o = (w_count != PtrW'(els_p));
  assign v_o     = (r_iptr != r_wptr) & ~replay_i & ~flush_i;
  assign pkt_o   = r_mem[r_iptr[AddrW-1:0]];

  assign w_enq    = v_i & ready_o & ~flush_i;
  assign w_issue  = yumi_i & v_o;
  assign w_retire = retire_i & (w_inflight != '0) & ~flush_i;

  always_comb begin
    w_wptr_d = r_wptr;
    w_iptr_d = r_iptr;
    w_rptr_d = r_rptr;
    if (flush_i) begin
      w_wptr_d = '0;
      w_iptr_d = '0;
      w_rptr_d = '0;
    end else begin
      w_wptr_d = r_wptr + PtrW'(w_enq);
      w_rptr_d = r_rptr + PtrW'(w_retire);
      // Replay rewinds to the oldest op still unretired after this cycle's retire.
      if (replay_i) w_iptr_d = r_rptr + PtrW'(w_retire);
      else          w_iptr_d = r_iptr + PtrW'(w_issue);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_iptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_d;
      r_iptr <= w_iptr_d;
      r_rptr <= w_rptr_d;
    end
  end

  // Payload storage is never cleared; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[AddrW-1:0]] <= pkt_i;
  end

endmodule
